keypad_scanner: RTL

Matrix-keypad front end for the game boards: scans the 4x3 keypad, debounces the full key map, and presents the game core with held key levels (`key0`, `key8`, `key_star`) and a one-cycle key-press event stream. It is the input end of the same key interface the game top consumes, replacing raw switch wiring with a scanned, debounced, glitch-free source.

---
 rtl/keypad_pkg.sv | 52 +++++
 rtl/keypad_debounce.sv | 61 ++++++
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x3 matrix keypad front end.
// Key map bit index is row*NUM_COLS+col; codes follow the printed keypad legend.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam int IDX_0    = 10;
    localparam int IDX_8    = 7;
    localparam int IDX_STAR = 9;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_state_t;

    // Map bit index to key code: rows 0..2 are digits 1..9, bottom row is *, 0, #.
    function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
        case (idx)
            4'd9:    return KEY_STAR;
            4'd10:   return KEY_0;
            4'd11:   return KEY_HASH;
            default: return idx + 4'd1;
        endcase
    endfunction

    // Number of keys set in a map.
    function automatic logic [3:0] count_keys(input logic [NUM_KEYS-1:0] map);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + {3'b000, map[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a new key map is accepted only after DEBOUNCE_CNT
// identical consecutive frames. With KEYPAD_MULTI_REJECT_EN defined, frames
// showing more than two keys are discarded as possible ghosting.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_vld,
    input  logic [NUM_KEYS-1:0] frame,
    output logic                load,
    output logic [NUM_KEYS-1:0] deb_map
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CNT);

    logic [NUM_KEYS-1:0] prev_frame;
    logic [3:0]          stab_cnt;
    logic [3:0]          stab_cnt_nxt;
    logic                accept;

    // Decide whether this frame counts and what the stable counter becomes.
    always_comb begin
        accept = frame_vld;
`ifdef KEYPAD_MULTI_REJECT_EN
        if (count_keys(frame) > 4'd2) begin
            accept = 1'b0;
        end
`endif
        if (frame == prev_frame) begin
            stab_cnt_nxt = (stab_cnt >= CNT_MAX) ? CNT_MAX : stab_cnt + 4'd1;
        end else begin
            stab_cnt_nxt = 4'd1;
        end
        load = accept && (stab_cnt_nxt == CNT_MAX);
    end

    // Frame history, stable counter and debounced map.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_frame <= '0;
            stab_cnt   <= '0;
            deb_map    <= '0;
        end else if (accept) begin
            prev_frame <= frame;
            stab_cnt   <= stab_cnt_nxt;
            if (load) begin
                deb_map <= frame;
            end
        end
`ifdef KEYPAD_MULTI_REJECT_EN
        else if (frame_vld) begin
            // Rejected frame: restart qualification, keep the last good frame.
            stab_cnt <= '0;
        end
`endif
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: drives one column low per slot, builds a raw key map,
// debounces it per frame and reports each new press as a one-cycle event.
// Optional build macro KEYPAD_MULTI_REJECT_EN discards frames with >2 keys.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 5000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic                key_valid,
    output logic [3:0]          key_code,
    output logic                key0,
    output logic                key8,
    output logic                key_star
);

    localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [NUM_ROWS-1:0] row_p0;
    logic [NUM_ROWS-1:0] row_p1;
    col_state_t          col_state;
    logic [CNT_W-1:0]    slot_cnt;
    logic [NUM_KEYS-1:0] raw_map;
    logic [NUM_KEYS-1:0] raw_next;
    logic                frame_vld;
    logic                load;
    logic [NUM_KEYS-1:0] deb_map;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] pending_nxt;
    logic [NUM_KEYS-1:0] low_bit;
    logic [3:0]          low_idx;
    logic [NUM_KEYS-1:0] rise;

    // Two-flop synchroniser for the asynchronous, pulled-up row lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_p0 <= '1;
            row_p1 <= '1;
        end else begin
            row_p0 <= row_in;
            row_p1 <= row_p0;
        end
    end

    // Raw map with the active column's rows (inverted to active-high) merged in.
    always_comb begin
        raw_next = raw_map;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (c == int'(col_state)) begin
                    raw_next[r*NUM_COLS + c] = ~row_p1[r];
                end
            end
        end
    end

    // Column FSM: SCAN_DIV cycles per column, rows sampled on the slot's last cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_state <= COL0;
            col_out   <= 3'b110;
            slot_cnt  <= '0;
            raw_map   <= '0;
            frame_vld <= 1'b0;
        end else begin
            frame_vld <= 1'b0;
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                raw_map  <= raw_next;
                case (col_state)
                    COL0: begin
                        col_state <= COL1;
                        col_out   <= 3'b101;
                    end
                    COL1: begin
                        col_state <= COL2;
                        col_out   <= 3'b011;
                    end
                    COL2: begin
                        col_state <= COL0;
                        col_out   <= 3'b110;
                        frame_vld <= 1'b1;
                    end
                    default: begin
                        col_state <= COL0;
                        col_out   <= 3'b110;
                    end
                endcase
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .frame_vld (frame_vld),
        .frame     (raw_map),
        .load      (load),
        .deb_map   (deb_map)
    );

    // Pick the lowest pending key and merge newly debounced presses.
    always_comb begin
        low_bit = '0;
        low_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_bit = NUM_KEYS'(1) << i;
                low_idx = 4'(i);
            end
        end
        rise        = load ? (raw_map & ~deb_map) : '0;
        pending_nxt = (pending & ~low_bit) | rise;
    end

    // Press reporter: one key per cycle in ascending bit order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            pending   <= pending_nxt;
            key_valid <= |pending;
            if (|pending) begin
                key_code <= idx_to_code(low_idx);
            end
        end
    end

    assign key0     = deb_map[IDX_0];
    assign key8     = deb_map[IDX_8];
    assign key_star = deb_map[IDX_STAR];

endmodule
